udp_fdma_ddr_rstream: RTL and testbench
=======================================

Name: udp_fdma_ddr_rstream

Overview:
- Read-side counterpart of the UDP→DDR write buffering path: fetches a frame of 32-bit words from DDR through the FDMA read channel and streams it to the UDP transmit datapath.
- Issues FDMA read bursts only when the internal 128-word buffer has room for the whole burst; the FDMA read channel never needs to stall.
- Presents data to the UDP TX side as a valid/ready stream with a last marker on the final word.

Parameters:
- ADDR_W, 32, DDR byte-address width.
- LEN_W, 16, width of the frame-length field (in words).
- BURST_LEN, 32, maximum words per FDMA read burst (power of two, ≤ FIFO_DEPTH).
- FIFO_AW, 7, buffer address width; depth = 2^FIFO_AW = 128 words.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr/len_words; ignored unless busy=0.
- base_addr  in  ADDR_W  DDR byte address of the first word (4-byte aligned).
- len_words  in  LEN_W  frame length in 32-bit words; 0 = no-op.
- busy  out  1  high from the accepted start until the last word handshakes on tx.
- done  out  1  one-cycle pulse on the cycle after the last tx handshake.
- fdma_rareq  out  1  burst request; held until fdma_rbusy is seen high.
- fdma_raddr  out  ADDR_W  burst start byte address; stable while fdma_rareq=1.
- fdma_rsize  out  LEN_W  burst length in words; stable while fdma_rareq=1.
- fdma_rbusy  in  1  FDMA burst in progress.
- fdma_rvalid  in  1  read data beat valid.
- fdma_rdata  in  32  read data.
- tx_data  out  32  stream data (show-ahead head of buffer).
- tx_valid  out  1  buffer not empty.
- tx_ready  in  1  UDP TX accepts word.
- tx_last  out  1  high with the final word of the frame.
- fifo_level  out  FIFO_AW+1  current buffer occupancy (0..128).

Behaviour:
- Reset values: busy=0, done=0, fdma_rareq=0, fdma_raddr=0, fdma_rsize=0, tx_valid=0, tx_last=0, fifo_level=0, tx_data=0. The FSM returns to IDLE.
- FSM states:
  - IDLE: start with len_words≠0 → latch addr/remaining → CHECK. start with len_words=0 → done pulse next cycle, busy stays 0.
  - CHECK: compute bsz = min(BURST_LEN, remaining). If free = 128 − fifo_level − inflight ≥ bsz → REQ, else stay.
  - REQ: fdma_rareq=1 with raddr/rsize set. When fdma_rbusy=1 → BURST.
  - BURST: count fdma_rvalid beats. When count = bsz and fdma_rbusy=0: addr += bsz×4 (wraps modulo 2^ADDR_W), remaining −= bsz. Then remaining=0 → DRAIN, else → CHECK.
  - DRAIN: wait until the final word handshakes → done pulse → IDLE.
- Each rvalid beat writes the buffer the same cycle. A beat arriving when the buffer is full is a protocol error: the beat is dropped and the overflow is a sticky internal flag visible to assertions. The credit check in CHECK makes this unreachable.
- Read side is show-ahead:
  - tx_data is the head word; tx_valid = (level≠0).
  - A handshake is tx_valid & tx_ready; the next word appears the following cycle, zero-bubble.
- tx_last = tx_valid & (words_sent = len−1).
- fifo_level updates every cycle:
  - simultaneous write and read → unchanged;
  - full with write and read in the same cycle → both accepted.
- Pointers are FIFO_AW+1 bits; full/empty come from the MSB compare; wrap-around is natural.
- start while busy=1 is ignored and has no effect on any state.
- Reset mid-burst clears all state immediately. Any beats still arriving are discarded because the FSM is in IDLE.
- Latency: start → fdma_rareq in 2 cycles (IDLE→CHECK→REQ). First rvalid → tx_valid in 1 cycle.

Decomposition:
- Shared package udp_fdma_pkg holds:
  - FSM state enum (IDLE, CHECK, REQ, BURST, DRAIN);
  - word width 32 and the byte-per-word shift constant 2;
  - default BURST_LEN/FIFO_AW.
- One sub-module: udp_fdma_rbuf. It is a single-clock show-ahead circular buffer (dual-port array, wr/rd pointers, level, full/empty) and is instantiated once.
- Burst sequencing, credit check and tx_last counting stay in the top.

Test Plan:
- start, base_addr=0x1000, len_words=64, tx_ready=1, FDMA returns beats back-to-back → two bursts:
  - (0x1000, 32) and (0x1080, 32);
  - 64 tx words in order, tx_last only on word 63;
  - done one cycle after it; busy then 0.
- len_words=40 → bursts of sizes 32 then 8 at 0x1000/0x1080; tx_last on word 39.
- tx_ready=0, len_words=256:
  - exactly 4 bursts are issued, then fdma_rareq stays 0 with fifo_level=128;
  - releasing tx_ready resumes requests;
  - no overflow flag is set.
- tx_ready toggling every cycle during simultaneous rvalid beats → fifo_level never exceeds 128, data is the sequential pattern with no loss or duplication.
- rst_n asserted low mid-BURST after 10 beats → all outputs return to reset values the same cycle. A new start of len 32 then completes cleanly.
- start with len_words=0 → no fdma_rareq, done pulse one cycle later. start pulsed while busy → ignored, the original frame is unaffected.

Source files
------------

// File: rtl/udp_fdma_pkg.sv
// -----------------------------------------------------------------------------
// udp_fdma_pkg
// Shared definitions for the DDR read-stream path: FSM state encoding, data
// word width, byte/word address shift and default sizing of the burst and the
// internal buffer.
// -----------------------------------------------------------------------------
package udp_fdma_pkg;

    localparam int WORD_W        = 32;
    localparam int BYTE_SHIFT    = 2;   // byte address = word index << 2
    localparam int DEF_BURST_LEN = 32;
    localparam int DEF_FIFO_AW   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_BURST,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/udp_fdma_rbuf.sv
// -----------------------------------------------------------------------------
// udp_fdma_rbuf
// Single-clock show-ahead circular buffer. The head word is always presented
// on rd_data_o (zero while empty); a read strobe advances to the next word,
// which appears the following cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en_i      write strobe, wr_data_i stored on the same edge
//   rd_en_i      consumer accepts the head word (ignored while empty)
//   rd_data_o    head word
//   level_o      occupancy, 0 .. 2^AW
//   empty_o      buffer empty
//   overflow_o   sticky: a write arrived while full with no read to free a slot
// -----------------------------------------------------------------------------
module udp_fdma_rbuf
    import udp_fdma_pkg::*;
#(
    parameter int AW = DEF_FIFO_AW,
    parameter int DW = WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic [AW:0]   level_o,
    output logic          empty_o,
    output logic          overflow_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          overflow_q;
    logic          full_w;
    logic          rd_fire_w;
    logic          wr_fire_w;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_w    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_fire_w = rd_en_i & ~empty_o;
    // When full, a simultaneous read frees the slot the write lands in.
    assign wr_fire_w = wr_en_i & (~full_w | rd_fire_w);

    always_ff @(posedge clk) begin
        if (wr_fire_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_fire_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire_w) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en_i && !wr_fire_w) overflow_q <= 1'b1;
        end
    end

    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/udp_fdma_ddr_rstream.sv
// -----------------------------------------------------------------------------
// udp_fdma_ddr_rstream
// Fetches a frame of 32-bit words from DDR over the FDMA read channel and
// streams it to the UDP TX datapath. Bursts are only requested once the
// buffer has room for the whole burst, so the FDMA side never stalls.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, len_words frame request (accepted only while idle)
//   busy, done                 frame in progress / one-cycle completion pulse
//   fdma_rareq/raddr/rsize     burst request, held until fdma_rbusy seen
//   fdma_rbusy/rvalid/rdata    FDMA read channel return path
//   tx_data/valid/ready/last   show-ahead output stream
//   fifo_level                 buffer occupancy
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// CHECK    | size next burst, wait for enough free buffer space
// REQ      | fdma_rareq asserted, waiting for fdma_rbusy
// BURST    | collecting beats until the burst is complete
// DRAIN    | all words fetched, waiting for the final tx handshake
// -----------------------------------------------------------------------------
module udp_fdma_ddr_rstream
    import udp_fdma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int FIFO_AW   = DEF_FIFO_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len_words,
    output logic                busy,
    output logic                done,
    output logic                fdma_rareq,
    output logic [ADDR_W-1:0]   fdma_raddr,
    output logic [LEN_W-1:0]    fdma_rsize,
    input  logic                fdma_rbusy,
    input  logic                fdma_rvalid,
    input  logic [WORD_W-1:0]   fdma_rdata,
    output logic [WORD_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic [FIFO_AW:0]    fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   remain_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   sent_q;
    logic [LEN_W-1:0]   bsz_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               rareq_q;
    logic [ADDR_W-1:0]  raddr_q;
    logic [LEN_W-1:0]   rsize_q;

    logic               in_burst_w;
    logic               wr_en_w;
    logic               rd_hs_w;
    logic               empty_w;
    logic               overflow_w;
    logic               last_word_w;
    logic [LEN_W-1:0]   bsz_w;
    logic [LEN_W-1:0]   inflight_w;
    logic [LEN_W-1:0]   free_w;

    // Beats are only accepted while a burst is outstanding; stragglers after
    // a reset land while idle and are dropped.
    assign in_burst_w  = (state_q == ST_REQ) || (state_q == ST_BURST);
    assign wr_en_w     = fdma_rvalid & in_burst_w;
    assign rd_hs_w     = tx_valid & tx_ready;
    assign last_word_w = busy_q & (sent_q == len_q - LEN_W'(1));

    assign bsz_w      = (remain_q < LEN_W'(BURST_LEN)) ? remain_q : LEN_W'(BURST_LEN);
    assign inflight_w = in_burst_w ? (bsz_q - beat_cnt_q) : '0;
    assign free_w     = LEN_W'(DEPTH) - LEN_W'(fifo_level) - inflight_w;

    udp_fdma_rbuf #(
        .AW (FIFO_AW),
        .DW (WORD_W)
    ) u_rbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_w),
        .wr_data_i  (fdma_rdata),
        .rd_en_i    (tx_ready),
        .rd_data_o  (tx_data),
        .level_o    (fifo_level),
        .empty_o    (empty_w),
        .overflow_o (overflow_w)
    );

    assign tx_valid = ~empty_w;
    assign tx_last  = tx_valid & last_word_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            bsz_q      <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rareq_q    <= 1'b0;
            raddr_q    <= '0;
            rsize_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (rd_hs_w) sent_q <= sent_q + LEN_W'(1);
            if (wr_en_w) beat_cnt_q <= beat_cnt_q + LEN_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len_words == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q   <= 1'b1;
                            addr_q   <= base_addr;
                            remain_q <= len_words;
                            len_q    <= len_words;
                            sent_q   <= '0;
                            state_q  <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (free_w >= bsz_w) begin
                        bsz_q      <= bsz_w;
                        beat_cnt_q <= '0;
                        rareq_q    <= 1'b1;
                        raddr_q    <= addr_q;
                        rsize_q    <= bsz_w;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fdma_rbusy) begin
                        rareq_q <= 1'b0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if ((beat_cnt_q == bsz_q) && !fdma_rbusy) begin
                        addr_q   <= addr_q + (ADDR_W'(bsz_q) << BYTE_SHIFT);
                        remain_q <= remain_q - bsz_q;
                        state_q  <= (remain_q == bsz_q) ? ST_DRAIN : ST_CHECK;
                    end
                end
                ST_DRAIN: begin
                end
                default: state_q <= ST_IDLE;
            endcase

            // The final word can leave while the last burst is still closing,
            // so completion is taken from any active state.
            if (rd_hs_w && last_word_w) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                rareq_q <= 1'b0;
                state_q <= ST_IDLE;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fdma_rareq = rareq_q;
    assign fdma_raddr = raddr_q;
    assign fdma_rsize = rsize_q;

    // The credit check keeps the buffer from ever being written while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow_w);

endmodule

// File: tb/tb_udp_fdma_ddr_rstream.sv
module tb_udp_fdma_ddr_rstream;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        fdma_rareq;
    logic [31:0] fdma_raddr;
    logic [15:0] fdma_rsize;
    logic        fdma_rbusy;
    logic        fdma_rvalid;
    logic [31:0] fdma_rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic [7:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_hs_cyc = -1;
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: toggle
    bit gap_mode = 0;     // random idle cycles between FDMA beats

    logic [32:0] exp_q[$];    // {last, data} scoreboard
    logic [47:0] burst_q[$];  // {addr, size} seen by the FDMA model

    int          m_state = 0;
    int          m_cnt = 0;
    int          m_size = 0;
    logic [31:0] m_addr = 0;

    udp_fdma_ddr_rstream dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len_words   (len_words),
        .busy        (busy),
        .done        (done),
        .fdma_rareq  (fdma_rareq),
        .fdma_raddr  (fdma_raddr),
        .fdma_rsize  (fdma_rsize),
        .fdma_rbusy  (fdma_rbusy),
        .fdma_rvalid (fdma_rvalid),
        .fdma_rdata  (fdma_rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .fifo_level  (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // FDMA read channel model: data word = byte address / 4.
    initial begin
        fdma_rbusy = 1'b0;
        fdma_rvalid = 1'b0;
        fdma_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                fdma_rbusy = 1'b0;
                fdma_rvalid = 1'b0;
                m_state = 0;
            end else begin
                case (m_state)
                    0: begin
                        fdma_rvalid = 1'b0;
                        if (fdma_rareq) begin
                            burst_q.push_back({fdma_raddr, fdma_rsize});
                            m_addr = fdma_raddr;
                            m_size = int'(fdma_rsize);
                            m_cnt = 0;
                            fdma_rbusy = 1'b1;
                            m_state = 1;
                        end
                    end
                    1: begin
                        if (gap_mode && $urandom_range(0, 2) == 0) begin
                            fdma_rvalid = 1'b0;
                        end else begin
                            fdma_rvalid = 1'b1;
                            fdma_rdata = (m_addr >> 2) + 32'(m_cnt);
                            m_cnt++;
                            if (m_cnt == m_size) m_state = 2;
                        end
                    end
                    default: begin
                        fdma_rvalid = 1'b0;
                        fdma_rbusy = 1'b0;
                        m_state = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'b0;
                default: tx_ready = ~tx_ready;
            endcase
        end
    end

    // Scoreboard: pop and compare every accepted word.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            checks++;
            if (fifo_level > 8'd128) begin
                failures++;
                $display("FAIL level_bound got=%0d max=128", fifo_level);
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word got=%h last=%b expected none", tx_data, tx_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_last, tx_data} !== e) begin
                        failures++;
                        $display("FAIL tx_word got=%b/%h exp=%b/%h", tx_last, tx_data, e[32], e[31:0]);
                    end
                end
                if (tx_last) last_hs_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [31:0] b, input logic [15:0] l, input bit push);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        len_words = l;
        if (push) begin
            for (int k = 0; k < int'(l); k++) begin
                exp_q.push_back({(k == int'(l) - 1), (b >> 2) + 32'(k)});
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to, output int dcyc);
        to = 1'b1;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                to = 1'b0;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len_words = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, fdma_rareq, tx_valid, tx_last} !== 5'b0 || fdma_raddr !== 32'h0 ||
            fdma_rsize !== 16'h0 || fifo_level !== 8'h0 || tx_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got busy=%b done=%b rareq=%b raddr=%h rsize=%h valid=%b last=%b level=%0d data=%h exp all zero",
                     busy, done, fdma_rareq, fdma_raddr, fdma_rsize, tx_valid, tx_last, fifo_level, tx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, fdma_rareq, tx_valid} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b rareq=%b valid=%b exp 0", busy, done, fdma_rareq, tx_valid);
        end
    endtask

    task automatic test_two_bursts();
        bit to;
        int dc;
        logic [47:0] eb[$];
        ready_mode = 0;
        gap_mode = 0;
        burst_q.delete();
        start_frame(32'h1000, 16'd64, 1'b1);
        @(negedge clk);
        checks++;
        if (fdma_rareq !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL latency_c1 got rareq=%b busy=%b exp rareq=0 busy=1", fdma_rareq, busy);
        end
        @(negedge clk);
        checks++;
        if (fdma_rareq !== 1'b1 || fdma_raddr !== 32'h1000 || fdma_rsize !== 16'd32) begin
            failures++;
            $display("FAIL latency_c2 got rareq=%b raddr=%h rsize=%0d exp 1/1000/32", fdma_rareq, fdma_raddr, fdma_rsize);
        end
        wait_done(500, to, dc);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL two_bursts_done got timeout exp done");
        end
        checks++;
        if (dc != last_hs_cyc + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL two_bursts_done_timing got cyc=%0d busy=%b exp cyc=%0d busy=0", dc, busy, last_hs_cyc + 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width got=%b exp=0", done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL two_bursts_words_left got=%0d exp=0", exp_q.size());
        end
        eb.push_back({32'h1000, 16'd32});
        eb.push_back({32'h1080, 16'd32});
        checks++;
        if (burst_q.size() != eb.size()) begin
            failures++;
            $display("FAIL two_bursts_count got=%0d exp=%0d", burst_q.size(), eb.size());
        end else begin
            foreach (eb[i]) begin
                checks++;
                if (burst_q[i] !== eb[i]) begin
                    failures++;
                    $display("FAIL two_bursts_req%0d got=%h exp=%h", i, burst_q[i], eb[i]);
                end
            end
        end
    endtask

    task automatic test_short_tail();
        bit to;
        int dc;
        logic [47:0] eb[$];
        ready_mode = 0;
        gap_mode = 1;
        burst_q.delete();
        start_frame(32'h1000, 16'd40, 1'b1);
        wait_done(800, to, dc);
        gap_mode = 0;
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL short_tail_done got timeout=%b left=%0d exp 0/0", to, exp_q.size());
        end
        eb.push_back({32'h1000, 16'd32});
        eb.push_back({32'h1080, 16'd8});
        checks++;
        if (burst_q.size() != eb.size()) begin
            failures++;
            $display("FAIL short_tail_count got=%0d exp=%0d", burst_q.size(), eb.size());
        end else begin
            foreach (eb[i]) begin
                checks++;
                if (burst_q[i] !== eb[i]) begin
                    failures++;
                    $display("FAIL short_tail_req%0d got=%h exp=%h", i, burst_q[i], eb[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        bit seen_req;
        int dc;
        logic [31:0] a;
        ready_mode = 1;
        gap_mode = 0;
        burst_q.delete();
        start_frame(32'h2000, 16'd256, 1'b1);
        to = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (fifo_level == 8'd128) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin
            failures++;
            $display("FAIL bp_fill got level=%0d exp=128", fifo_level);
        end
        seen_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fdma_rareq) seen_req = 1'b1;
        end
        checks++;
        if (seen_req || burst_q.size() != 4 || fifo_level !== 8'd128) begin
            failures++;
            $display("FAIL bp_hold got req=%b bursts=%0d level=%0d exp 0/4/128", seen_req, burst_q.size(), fifo_level);
        end
        ready_mode = 0;
        wait_done(1500, to, dc);
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_resume got timeout=%b left=%0d exp 0/0", to, exp_q.size());
        end
        checks++;
        if (burst_q.size() != 8) begin
            failures++;
            $display("FAIL bp_bursts got=%0d exp=8", burst_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                a = 32'h2000 + 32'(i * 128);
                checks++;
                if (burst_q[i] !== {a, 16'd32}) begin
                    failures++;
                    $display("FAIL bp_req%0d got=%h exp=%h", i, burst_q[i], {a, 16'd32});
                end
            end
        end
        checks++;
        if (dut.u_rbuf.overflow_q !== 1'b0) begin
            failures++;
            $display("FAIL bp_overflow got=%b exp=0", dut.u_rbuf.overflow_q);
        end
    endtask

    task automatic test_toggle();
        bit to;
        int dc;
        ready_mode = 2;
        gap_mode = 0;
        burst_q.delete();
        start_frame(32'h6000, 16'd96, 1'b1);
        wait_done(1500, to, dc);
        ready_mode = 0;
        checks++;
        if (to || exp_q.size() != 0 || burst_q.size() != 3) begin
            failures++;
            $display("FAIL toggle_frame got timeout=%b left=%0d bursts=%0d exp 0/0/3", to, exp_q.size(), burst_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        int dc;
        ready_mode = 1;
        gap_mode = 0;
        burst_q.delete();
        start_frame(32'h3000, 16'd64, 1'b1);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_state == 1 && m_cnt >= 10) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin
            failures++;
            $display("FAIL mid_burst_reach got beats=%0d exp>=10", m_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, fdma_rareq, tx_valid, tx_last} !== 5'b0 || fdma_raddr !== 32'h0 ||
            fdma_rsize !== 16'h0 || fifo_level !== 8'h0 || tx_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_burst_reset got busy=%b rareq=%b raddr=%h rsize=%h valid=%b level=%0d data=%h exp all zero",
                     busy, fdma_rareq, fdma_raddr, fdma_rsize, tx_valid, fifo_level, tx_data);
        end
        exp_q.delete();
        burst_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        start_frame(32'h4000, 16'd32, 1'b1);
        wait_done(300, to, dc);
        checks++;
        if (to || exp_q.size() != 0 || burst_q.size() != 1) begin
            failures++;
            $display("FAIL post_reset_frame got timeout=%b left=%0d bursts=%0d exp 0/0/1", to, exp_q.size(), burst_q.size());
        end else begin
            checks++;
            if (burst_q[0] !== {32'h4000, 16'd32}) begin
                failures++;
                $display("FAIL post_reset_req got=%h exp=%h", burst_q[0], {32'h4000, 16'd32});
            end
        end
    endtask

    task automatic test_zero_len();
        bit seen_req;
        burst_q.delete();
        start_frame(32'h7000, 16'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done got done=%b busy=%b exp 1/0", done, busy);
        end
        seen_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fdma_rareq || busy || done) seen_req = 1'b1;
        end
        checks++;
        if (seen_req || burst_q.size() != 0) begin
            failures++;
            $display("FAIL zero_len_quiet got activity=%b bursts=%0d exp 0/0", seen_req, burst_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        bit seen_req;
        int dc;
        ready_mode = 0;
        burst_q.delete();
        start_frame(32'h5000, 16'd48, 1'b1);
        repeat (3) @(negedge clk);
        start_frame(32'h9000, 16'd16, 1'b0);
        wait_done(400, to, dc);
        checks++;
        if (to || exp_q.size() != 0 || burst_q.size() != 2) begin
            failures++;
            $display("FAIL busy_start_frame got timeout=%b left=%0d bursts=%0d exp 0/0/2", to, exp_q.size(), burst_q.size());
        end else begin
            checks++;
            if (burst_q[0] !== {32'h5000, 16'd32} || burst_q[1] !== {32'h5080, 16'd16}) begin
                failures++;
                $display("FAIL busy_start_reqs got=%h,%h exp=%h,%h", burst_q[0], burst_q[1],
                         {32'h5000, 16'd32}, {32'h5080, 16'd16});
            end
        end
        seen_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fdma_rareq || busy) seen_req = 1'b1;
        end
        checks++;
        if (seen_req) begin
            failures++;
            $display("FAIL busy_start_after got activity=1 exp=0");
        end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_short_tail();
        test_backpressure();
        test_toggle();
        test_reset_mid_burst();
        test_zero_len();
        test_start_while_busy();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
